router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet transmitter that drives the router's input byte stream: header, payload, then parity.
- Local logic preloads a packet's payload into an internal buffer, then issues a send.
- The block then streams the packet to the router without bubbles, stalling only while router_busy is high.
- Used as the upstream source in front of the router, and as the bench driver for it.

Parameters:
- MAX_LEN, 63, maximum payload bytes. Must be ≤63 because the header length field is 6 bits.
- IFG, 2, idle cycles inserted after the parity byte before the next send is accepted. Must be ≥1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write wr_data into the payload buffer.
- wr_data  input  8  payload byte.
- send  input  1  start transmission of the buffered payload.
- dest  input  2  destination port address, placed in header bits [1:0].
- corrupt_parity  input  1  sampled with send; when 1, the bitwise inverse of the parity is sent.
- router_busy  input  1  router cannot accept a byte this cycle.
- data_out  output  8  byte to the router (router data_in).
- pkt_valid  output  1  high while header and payload bytes are on data_out.
- tx_busy  output  1  block is not in IDLE.
- wr_count  output  6  payload bytes currently buffered.
- done  output  1  one-cycle pulse when the parity byte is accepted.
- err  output  1  one-cycle pulse on any rejected request.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-packet):
  - data_out=0, pkt_valid=0, tx_busy=0, done=0, err=0, wr_count=0.
  - FSM goes to IDLE; buffer read and write pointers go to 0.
  - Buffer contents are don't-care.
- States: IDLE, HDR, PLD, PAR, GAP. All outputs are registered.
- IDLE:
  - wr_en with wr_count<MAX_LEN: store byte at buffer[wr_count], wr_count+1.
  - wr_en with wr_count==MAX_LEN: byte dropped, err pulse.
  - send with wr_count>0: latch dest, length=wr_count and corrupt_parity. On that edge, go to HDR with data_out={wr_count[5:0],dest}, pkt_valid=1, tx_busy=1. The parity accumulator loads the header byte.
  - send with wr_count==0: ignored, err pulse, stay in IDLE.
  - send and wr_en in the same cycle: send wins, the write is dropped, err pulse.
- Transfer rule: in HDR, PLD or PAR, the byte on data_out is accepted at a rising edge where router_busy==0. While router_busy==1, data_out, pkt_valid and the state hold unchanged.
- HDR, on accept: go to PLD, data_out=buffer[0], rd_ptr=1, parity ^= buffer[0].
- PLD, on accept:
  - If rd_ptr<length: data_out=buffer[rd_ptr], rd_ptr+1, parity ^= that byte.
  - Otherwise: go to PAR, data_out=parity (or ~parity if corrupt latched), pkt_valid=0.
- PAR, on accept: go to GAP, data_out=0, done=1 for one cycle, wr_count=0, and load the GAP counter with IFG.
- GAP: counts IFG cycles with pkt_valid=0, then returns to IDLE with tx_busy=0.
- In any non-IDLE state, wr_en or send is ignored with an err pulse. No buffer or state change occurs.
- Parity: 8-bit XOR of the header and all payload bytes, matching the router's checker.
- Timing: with router_busy held low, a packet of N payload bytes occupies exactly N+2 consecutive cycles on data_out. pkt_valid is high for N+1 of them. The first byte appears one clock after send is sampled.
- done and err are single-cycle pulses, deasserted otherwise.

Test Plan:
- Basic packet:
  - Stimulus: reset; write 8 bytes 0x01..0x08; send with dest=2, router_busy=0.
  - Required: header 0x22, then 0x01..0x08 with pkt_valid=1, then parity 0x2A with pkt_valid=0; done on the parity-accept edge; tx_busy low IFG cycles later; wr_count=0.
- Stall:
  - Stimulus: same packet; raise router_busy for 3 cycles while byte 0x04 is on data_out.
  - Required: 0x04 holds for 4 cycles, then the sequence resumes; total 13 cycles; parity unchanged (0x2A).
- Corrupt parity:
  - Stimulus: same packet sent with corrupt_parity=1.
  - Required: parity byte is 0xD5; all other bytes unchanged.
- Illegal requests:
  - Stimulus: send with wr_count=0; then write 63 bytes and a 64th; then wr_en together with send.
  - Required: err pulses for each; wr_count stays 63; the packet sends 63 bytes with header 0xFC|dest.
- Busy rejection:
  - Stimulus: send and wr_en during PLD.
  - Required: err pulses; the packet in flight is unaffected; wr_count is unchanged until done.
- Reset mid-packet:
  - Stimulus: assert reset during PLD.
  - Required: data_out=0, pkt_valid=0, tx_busy=0, wr_count=0 immediately; next send with an empty buffer gives an err pulse.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Byte-stream bundle between local logic, the packet transmitter and the router.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       send;
    logic [1:0] dest;
    logic       corrupt_parity;
    logic       router_busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic [5:0] wr_count;
    logic       done;
    logic       err;

    modport master (
        input  wr_en, wr_data, send, dest, corrupt_parity, router_busy,
        output data_out, pkt_valid, tx_busy, wr_count, done, err
    );

    modport slave (
        output wr_en, wr_data, send, dest, corrupt_parity, router_busy,
        input  data_out, pkt_valid, tx_busy, wr_count, done, err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a payload, then streams header/payload/parity to the router with no bubbles.
// First byte one clock after send; holds the current byte while router_busy is high.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int IFG     = 2
) (
    input  logic            clk,
    input  logic            reset,
    router_pkt_tx_if.master bus
);
    localparam int GW = $clog2(IFG + 1);

    typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    buffer [64];
    logic [7:0]    rd_byte;
    logic          accept, buf_we;

    logic [7:0]    data_q, data_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          tx_busy_q, tx_busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [5:0]    wr_count_q, wr_count_d;
    logic [5:0]    rd_ptr_q, rd_ptr_d;
    logic [5:0]    length_q, length_d;
    logic [7:0]    parity_q, parity_d;
    logic          corrupt_q, corrupt_d;
    logic [GW-1:0] gap_q, gap_d;

    assign accept  = !bus.router_busy;
    assign rd_byte = buffer[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.send && wr_count_q != 6'd0) state_d = HDR;
            HDR:  if (accept) state_d = PLD;
            PLD:  if (accept && rd_ptr_q >= length_q) state_d = PAR;
            PAR:  if (accept) state_d = GAP;
            GAP:  if (gap_q <= GW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        tx_busy_d   = (state_d != IDLE);
        done_d      = 1'b0;
        err_d       = 1'b0;
        wr_count_d  = wr_count_q;
        rd_ptr_d    = rd_ptr_q;
        length_d    = length_q;
        parity_d    = parity_q;
        corrupt_d   = corrupt_q;
        gap_d       = gap_q;
        buf_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A send always takes priority; a concurrent write is dropped.
                if (bus.send) begin
                    if (wr_count_q != 6'd0) begin
                        data_d      = {wr_count_q, bus.dest};
                        parity_d    = {wr_count_q, bus.dest};
                        pkt_valid_d = 1'b1;
                        length_d    = wr_count_q;
                        corrupt_d   = bus.corrupt_parity;
                        rd_ptr_d    = 6'd0;
                    end
                    err_d = (wr_count_q == 6'd0) || bus.wr_en;
                end else if (bus.wr_en) begin
                    if (wr_count_q < 6'(MAX_LEN)) begin
                        buf_we     = 1'b1;
                        wr_count_d = wr_count_q + 6'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR, PLD: begin
                // rd_ptr is 0 in HDR, so the header accept fetches buffer[0].
                if (accept) begin
                    if (rd_ptr_q < length_q) begin
                        data_d   = rd_byte;
                        rd_ptr_d = rd_ptr_q + 6'd1;
                        parity_d = parity_q ^ rd_byte;
                    end else begin
                        data_d      = parity_q ^ {8{corrupt_q}};
                        pkt_valid_d = 1'b0;
                    end
                end
            end
            PAR: begin
                if (accept) begin
                    data_d     = 8'd0;
                    done_d     = 1'b1;
                    wr_count_d = 6'd0;
                    gap_d      = GW'(IFG);
                end
            end
            GAP: if (gap_q > GW'(1)) gap_d = gap_q - GW'(1);
            default: ;
        endcase
        if (state_q != IDLE && (bus.send || bus.wr_en)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q      <= 8'd0;
            pkt_valid_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_count_q  <= 6'd0;
            rd_ptr_q    <= 6'd0;
            length_q    <= 6'd0;
            parity_q    <= 8'd0;
            corrupt_q   <= 1'b0;
            gap_q       <= '0;
        end else begin
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            tx_busy_q   <= tx_busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
            rd_ptr_q    <= rd_ptr_d;
            length_q    <= length_d;
            parity_q    <= parity_d;
            corrupt_q   <= corrupt_d;
            gap_q       <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buffer[wr_count_q] <= bus.wr_data;
    end

    assign bus.data_out  = data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized bench for router_pkt_tx against a byte-stream reference model.
module tb_router_pkt_tx;
    localparam int MAX_LEN = 63;
    localparam int IFG     = 2;
    localparam int BOUND   = 2000;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit [7:0] mq[$];

    router_pkt_tx_if bus ();

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .IFG(IFG)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input bit [7:0] b);
        bit exp_err;
        exp_err = (mq.size() >= MAX_LEN);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (!exp_err) mq.push_back(b);
        chk("wr_err", bus.err, exp_err);
        chk("wr_count", bus.wr_count, mq.size());
    endtask

    // Sends the model's buffered payload and checks every cycle of the resulting stream.
    task automatic send_pkt(input bit [1:0] d, input bit corr, input bit also_wr,
                            input int stall_at, input int stall_len, input bit rnd_busy,
                            input int inj_idx, output int cycles);
        bit [7:0] exp[$];
        bit [7:0] p;
        int n, idx, stalls;
        bit busy, err_exp, injected;
        n = mq.size();
        p = {n[5:0], d};
        exp.push_back(p);
        foreach (mq[i]) begin
            exp.push_back(mq[i]);
            p ^= mq[i];
        end
        exp.push_back(corr ? ~p : p);
        @(negedge clk);
        bus.send           = 1'b1;
        bus.dest           = d;
        bus.corrupt_parity = corr;
        bus.wr_en          = also_wr;
        bus.wr_data        = 8'hA5;
        @(negedge clk);
        idx = 0; cycles = 0; stalls = 0; err_exp = also_wr; injected = 0;
        while (idx < n + 2 && cycles < BOUND) begin
            chk("data_out", bus.data_out, exp[idx]);
            chk("pkt_valid", bus.pkt_valid, idx <= n);
            chk("tx_busy", bus.tx_busy, 1);
            chk("done_early", bus.done, 0);
            chk("err", bus.err, err_exp);
            chk("wr_count_hold", bus.wr_count, n);
            bus.send  = 1'b0;
            bus.wr_en = 1'b0;
            err_exp   = 1'b0;
            if (idx == inj_idx && !injected) begin
                bus.send  = 1'b1;
                bus.wr_en = 1'b1;
                injected  = 1'b1;
                err_exp   = 1'b1;
            end
            if (rnd_busy) busy = ($urandom_range(0, 3) == 0);
            else          busy = (idx == stall_at && stalls < stall_len);
            if (busy && idx == stall_at) stalls++;
            bus.router_busy = busy;
            @(negedge clk);
            cycles++;
            if (!busy) idx++;
        end
        chk("stream_timeout", cycles < BOUND, 1);
        bus.router_busy = 1'b0;
        bus.send        = 1'b0;
        bus.wr_en       = 1'b0;
        chk("done", bus.done, 1);
        chk("gap_data", bus.data_out, 0);
        chk("gap_valid", bus.pkt_valid, 0);
        chk("done_wr_count", bus.wr_count, 0);
        chk("gap_busy", bus.tx_busy, 1);
        for (int g = 1; g <= IFG; g++) begin
            @(negedge clk);
            chk("done_pulse", bus.done, 0);
            chk("ifg_busy", bus.tx_busy, g < IFG);
        end
        mq.delete();
    endtask

    initial begin
        int cyc;
        bus.wr_en = 0; bus.wr_data = 0; bus.send = 0; bus.dest = 0;
        bus.corrupt_parity = 0; bus.router_busy = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.pkt_valid, 0);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_count", bus.wr_count, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        reset = 1'b0;

        // Basic packet, header 0x22 / parity 0x2A
        for (int i = 1; i <= 8; i++) do_write(8'(i));
        send_pkt(2'd2, 1'b0, 1'b0, -1, 0, 1'b0, -1, cyc);
        chk("basic_cycles", cyc, 10);

        // Stall three cycles on byte 0x04
        for (int i = 1; i <= 8; i++) do_write(8'(i));
        send_pkt(2'd2, 1'b0, 1'b0, 4, 3, 1'b0, -1, cyc);
        chk("stall_cycles", cyc, 13);

        // Corrupt parity gives 0xD5
        for (int i = 1; i <= 8; i++) do_write(8'(i));
        send_pkt(2'd2, 1'b1, 1'b0, -1, 0, 1'b0, -1, cyc);

        // Illegal requests: empty send, overflow write, write together with send
        @(negedge clk); bus.send = 1'b1;
        @(negedge clk); bus.send = 1'b0;
        chk("empty_send_err", bus.err, 1);
        chk("empty_send_busy", bus.tx_busy, 0);
        for (int i = 0; i < MAX_LEN; i++) do_write(8'($urandom));
        do_write(8'hFF);
        chk("full_count", bus.wr_count, 63);
        send_pkt(2'd1, 1'b0, 1'b1, -1, 0, 1'b0, -1, cyc);

        // Requests during payload are rejected without disturbing the packet
        for (int i = 0; i < 10; i++) do_write(8'($urandom));
        send_pkt(2'd3, 1'b0, 1'b0, -1, 0, 1'b0, 3, cyc);

        // Randomized packets with random backpressure
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) do_write(8'($urandom));
            send_pkt(2'($urandom), 1'($urandom), 1'b0, -1, 0, 1'b1, -1, cyc);
        end

        // Asynchronous reset in the middle of the payload
        for (int i = 0; i < 5; i++) do_write(8'($urandom));
        @(negedge clk); bus.send = 1'b1; bus.dest = 2'd1; bus.corrupt_parity = 1'b0;
        @(negedge clk); bus.send = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", bus.pkt_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_data", bus.data_out, 0);
        chk("mid_rst_valid", bus.pkt_valid, 0);
        chk("mid_rst_busy", bus.tx_busy, 0);
        chk("mid_rst_count", bus.wr_count, 0);
        @(negedge clk); reset = 1'b0;
        mq.delete();
        @(negedge clk); bus.send = 1'b1;
        @(negedge clk); bus.send = 1'b0;
        chk("post_rst_err", bus.err, 1);
        chk("post_rst_busy", bus.tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
